// File: rtl/sobel_pkg.sv
// Shared types for the Sobel output path: pixel width, flag bit positions
// and the 11-bit framed word {eof, eol, sof, pixel}.
package sobel_pkg;

  localparam int PIX_W   = 8;
  localparam int SOF_BIT = 8;
  localparam int EOL_BIT = 9;
  localparam int EOF_BIT = 10;
  localparam int WORD_W  = 11;

  typedef logic [WORD_W-1:0] framed_pix_t;

  function automatic framed_pix_t pack_pix(input logic eof, input logic eol,
                                           input logic sof, input logic [PIX_W-1:0] pix);
    return {eof, eol, sof, pix};
  endfunction

endpackage

// File: rtl/sobel_out_framer_if.sv
// Framed ready/valid output stream of the Sobel framer.
interface sobel_out_framer_if;
  import sobel_pkg::*;

  logic             m_valid;
  logic             m_ready;
  logic [PIX_W-1:0] m_data;
  logic             m_sof;
  logic             m_eol;
  logic             m_eof;

  modport master (output m_valid, m_data, m_sof, m_eol, m_eof, input m_ready);
  modport slave  (input m_valid, m_data, m_sof, m_eol, m_eof, output m_ready);

endinterface

// File: rtl/sobel_sync_fifo.sv
// Synchronous FIFO of framed pixels with fall-through read; DEPTH must be a
// power of two so the pointers wrap naturally.
module sobel_sync_fifo
  import sobel_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  framed_pix_t              wdata_i,
  input  logic                     pop_i,
  output framed_pix_t              rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  framed_pix_t   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PW:0]   count_q, count_d;
  logic          wr_en, rd_en;

  assign full_o  = (count_q == (PW+1)'(DEPTH));
  assign empty_o = (count_q == {(PW+1){1'b0}});
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign wr_en   = push_i && !full_o;
  assign rd_en   = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({wr_en, rd_en})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      count_q  <= {(PW+1){1'b0}};
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_d;
    end
  end

  // Storage array is left unreset so it maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/sobel_out_framer.sv
// Re-frames the unstallable Sobel pixel stream into a tagged ready/valid stream.
// Optional build macro SOBEL_FRAMER_THRESH_EN adds a binarising threshold input.
module sobel_out_framer
  import sobel_pkg::*;
#(
  parameter int WIDTH      = 128,
  parameter int HEIGHT     = 128,
  parameter int FIFO_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [PIX_W-1:0] in_pixel,
`ifdef SOBEL_FRAMER_THRESH_EN
  input  logic [PIX_W-1:0] thresh,
`endif
  sobel_out_framer_if.master m_if,
  output logic             overflow,
  output logic             frame_done
);

  localparam int COL_W = $clog2(WIDTH);
  localparam int ROW_W = $clog2(HEIGHT);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(WIDTH - 3);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 3);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic             overflow_q, overflow_d;
  logic             frame_done_q, frame_done_d;
  logic             sof, eol, eof, push, pop;
  logic [PIX_W-1:0] store_pix;
  framed_pix_t      wdata, rdata;
  logic             fifo_full, fifo_empty;
  logic [CNT_W-1:0] fifo_count;

  // Counters advance on every strobe, stored or dropped, to keep framing aligned.
  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (in_valid) begin
      if (col_q == COL_LAST) begin
        col_d = {COL_W{1'b0}};
        if (row_q == ROW_LAST) begin
          row_d = {ROW_W{1'b0}};
        end else begin
          row_d = row_q + ROW_W'(1);
        end
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end else begin
      col_d = col_q;
      row_d = row_q;
    end
  end

  assign sof = (col_q == {COL_W{1'b0}}) && (row_q == {ROW_W{1'b0}});
  assign eol = (col_q == COL_LAST);
  assign eof = eol && (row_q == ROW_LAST);

`ifdef SOBEL_FRAMER_THRESH_EN
  assign store_pix = (in_pixel >= thresh) ? 8'd255 : 8'd0;
`else
  assign store_pix = in_pixel;
`endif

  assign wdata = pack_pix(eof, eol, sof, store_pix);
  // Input acceptance looks only at the registered count, never at m_ready.
  assign push  = in_valid && (fifo_count < CNT_W'(FIFO_DEPTH));
  assign pop   = m_if.m_valid && m_if.m_ready;

  assign overflow_d   = overflow_q || (in_valid && fifo_full);
  assign frame_done_d = pop && rdata[EOF_BIT];

  always_ff @(posedge clk) begin
    if (rst) begin
      col_q        <= {COL_W{1'b0}};
      row_q        <= {ROW_W{1'b0}};
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  sobel_sync_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (wdata),
    .pop_i   (pop),
    .rdata_o (rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Output fields are forced to zero while empty so reset reads all-zero.
  assign m_if.m_valid = !fifo_empty;
  assign m_if.m_data  = fifo_empty ? {PIX_W{1'b0}} : rdata[PIX_W-1:0];
  assign m_if.m_sof   = !fifo_empty && rdata[SOF_BIT];
  assign m_if.m_eol   = !fifo_empty && rdata[EOL_BIT];
  assign m_if.m_eof   = !fifo_empty && rdata[EOF_BIT];
  assign overflow     = overflow_q;
  assign frame_done   = frame_done_q;

endmodule

// File: doc/sobel_out_framer.md
Name: sobel_out_framer

Overview:
- Sink-side companion to the Sobel filter. Consumes its sparse, unstallable valid/pixel output stream and re-frames it into an AXI-Stream-style ready/valid stream.
- Tags each output pixel with start-of-frame, end-of-line and end-of-frame markers.
- Absorbs downstream backpressure in a small FIFO and flags data loss.
- Sits between the filter and the display/DMA writer.

Parameters:
- WIDTH, 128, input image width in pixels; output line length is WIDTH-2.
- HEIGHT, 128, input image height in lines; output frame height is HEIGHT-2.
- FIFO_DEPTH, 16, output FIFO entries; power of two, >= 2.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- in_valid  input  1  filter output pixel strobe; cannot be stalled.
- in_pixel  input  8  filter gradient magnitude.
- m_valid  output  1  output word available.
- m_ready  input  1  downstream accept.
- m_data  output  8  output pixel.
- m_sof  output  1  first pixel of frame.
- m_eol  output  1  last pixel of line.
- m_eof  output  1  last pixel of frame.
- overflow  output  1  sticky flag: a pixel was dropped.
- frame_done  output  1  one-cycle pulse when the EOF word is accepted.

Behaviour:
- Reset values: m_valid=0, m_data=0, m_sof=0, m_eol=0, m_eof=0, overflow=0, frame_done=0.
- Reset clears the FIFO pointers and count, and sets both counters to 0.
- Input counters: col_in (0..WIDTH-3) and row_in (0..HEIGHT-3).
  - Both advance on every in_valid, whether or not the pixel is stored.
  - col_in wraps at WIDTH-3, then row_in increments.
  - row_in wraps at HEIGHT-3, then the next frame starts with no gap.
- Tagging is computed at write from the pre-increment counters:
  - sof = (col_in==0 && row_in==0)
  - eol = (col_in==WIDTH-3)
  - eof = eol && (row_in==HEIGHT-3)
- FIFO word is 11 bits: {eof, eol, sof, pixel}.
- Push: in_valid && count<FIFO_DEPTH.
  - If in_valid && count==FIFO_DEPTH, the pixel is dropped and overflow is set next cycle. overflow holds until rst.
  - A push while full is dropped even if a pop occurs in the same cycle. There is no combinational path from m_ready to input accept.
- Pop:
  - m_valid = (count != 0).
  - m_data/m_sof/m_eol/m_eof = mem[rd_ptr], fall-through.
  - Pop when m_valid && m_ready.
  - While m_valid && !m_ready, all m_* outputs are held stable.
- Simultaneous push and pop with count not full: count unchanged, both pointers advance.
- Pointers wrap modulo FIFO_DEPTH.
- Latency: a pixel written at edge N is visible on m_* after edge N (m_valid=1 in cycle N+1) when the FIFO was empty. Throughput is 1 word/cycle.
- frame_done is registered: it is high the cycle after a pop of a word with eof=1.
- Reset mid-frame: the partial frame is discarded and the next in_valid is tagged sof.

Optional Feature:
- Macro SOBEL_FRAMER_THRESH_EN.
- Defined:
  - Extra input port thresh[7:0].
  - The stored pixel is (in_pixel >= thresh) ? 8'd255 : 8'd0, using unsigned compare and thresh sampled in the push cycle.
- Undefined: no thresh port; pixels pass unchanged.

Decomposition:
- Shared package sobel_pkg:
  - PIX_W=8
  - flag bit indices SOF_BIT=8, EOL_BIT=9, EOF_BIT=10
  - typedef framed_pix_t (11-bit packed word)
- Sub-module sobel_sync_fifo:
  - generic synchronous FIFO over framed_pix_t with DEPTH parameter and fall-through read.
  - outputs full, empty and count.
- Counters, tagging, overflow and frame_done logic live in the top module.

Test Plan:
- Clean frame: WIDTH=8, HEIGHT=6, 24 consecutive pixels 0..23, m_ready=1.
  - Outputs 0..23 in order.
  - m_sof only on 0; m_eol on 5, 11, 17, 23; m_eof only on 23.
  - frame_done pulses once; overflow=0.
- Backpressure: FIFO_DEPTH=16, m_ready=0 while 10 pixels are pushed, then m_ready=1.
  - m_data holds the first pixel during the stall.
  - All 10 pixels drain in order; overflow=0.
- Overflow: m_ready=0, 20 pixels pushed.
  - 16 stored; overflow=1 from the cycle after the 17th push.
  - After draining, the next frame's first pixel (index 24) carries m_sof=1, so framing is preserved.
- Reset mid-frame: assert rst after 10 pixels.
  - All outputs read 0 and m_valid=0.
  - The next pixel emerges with m_sof=1.
- Back-to-back frames: 48 pixels with no gap.
  - m_eof on 23 and 47; m_sof on 0 and 24; frame_done pulses twice.
- Threshold (SOBEL_FRAMER_THRESH_EN): thresh=100, inputs 99, 100, 255, 0 -> outputs 0, 255, 255, 0.
